// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the RISC-Net pipeline hazard controller.
//   OP_NOP / OP_MUL / OP_DIV : opcode constants seen in the IE stage
//   MUL_LAT_DEF / DIV_LAT_DEF: default execute latencies of the multi-cycle ops
//   state_t                  : controller FSM states (RUN, MULTI)
//   op_latency()             : number of cycles an opcode occupies IE
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MUL = 8'h0C;
  localparam logic [7:0] OP_DIV = 8'h0D;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 16;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  // The latencies are passed in so that an instance with non-default
  // MUL_LAT/DIV_LAT parameters gets its own values, not the package defaults.
  function automatic int op_latency(input logic [7:0] opcode,
                                    input int mulLat = MUL_LAT_DEF,
                                    input int divLat = DIV_LAT_DEF);
    case (opcode)
      OP_MUL:  return mulLat;
      OP_DIV:  return divLat;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the stage status signals coming from the pipeline and the
// enable/flush/bubble controls plus debug counters going back to it.
//   master : pipeline side, drives ID/IE status, receives controls
//   slave  : controller side, receives ID/IE status, drives controls
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int REG_AW = 4
);

  // Stage status from the pipeline
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic              id_src1_used;
  logic [REG_AW-1:0] id_src2;
  logic              id_src2_used;
  logic              ie_valid;
  logic [7:0]        ie_opcode;
  logic [REG_AW-1:0] ie_dest;
  logic              ie_is_load;
  logic              ie_branch_taken;

  // Controls and debug counters from the controller
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ie_en;
  logic              id_ie_bubble;
  logic              ie_busy;
  logic [15:0]       stall_count;
  logic [15:0]       flush_count;

  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           ie_valid, ie_opcode, ie_dest, ie_is_load, ie_branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ie_en, id_ie_bubble, ie_busy,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           ie_valid, ie_opcode, ie_dest, ie_is_load, ie_branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ie_en, id_ie_bubble, ie_busy,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   value : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next count: hold at all-ones so long runs never wrap back to small values.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != 16'hFFFF)) begin
      value_d = value_q + 16'd1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 16'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 4-stage RISC-Net pipeline.
// Stalls one cycle on load-use hazards, freezes the front end while a
// MUL/DIV holds IE, and flushes IF/ID and ID/IE on taken branches.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : pipeline_ctrl_if.slave (stage status in, controls/counters out)
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT <= 2) ? 1 : $clog2(MAX_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic pcEn, ifIdEn, ifIdFlush, idIeEn, idIeBubble, ieBusy;
  logic src1Hit, src2Hit, loadUse, branchFlush, isMultiOp, multiStart, multiHold;
  logic stallInc, flushInc;

  // Hazard comparator: register 0 is compared like any other index.
  assign src1Hit = bus.id_src1_used && (bus.id_src1 == bus.ie_dest);
  assign src2Hit = bus.id_src2_used && (bus.id_src2 == bus.ie_dest);
  assign loadUse = bus.ie_valid && bus.ie_is_load && bus.id_valid && (src1Hit || src2Hit);

  assign isMultiOp  = (bus.ie_opcode == OP_MUL) || (bus.ie_opcode == OP_DIV);
  assign multiHold  = (state_q == MULTI) && (cnt_q != '0);
  // Branches are only honoured when IE is not frozen by an ongoing MUL/DIV.
  assign branchFlush = !multiHold && bus.ie_valid && bus.ie_branch_taken;
  // Only RUN can start a multi-cycle op, so the op finishing in MULTI with
  // cnt==0 (still sitting in IE) does not start itself again.
  assign multiStart = (state_q == RUN) && bus.ie_valid && isMultiOp;

  // Mealy next-state and control decode; the if/else order is the priority
  // order, with the free-running case as the defaults.
  always_comb begin
    state_d    = RUN;
    cnt_d      = cnt_q;
    pcEn       = 1'b1;
    ifIdEn     = 1'b1;
    ifIdFlush  = 1'b0;
    idIeEn     = 1'b1;
    idIeBubble = 1'b0;
    ieBusy     = 1'b0;
    if (rst) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idIeEn     = 1'b0;
      ifIdFlush  = 1'b1;
      idIeBubble = 1'b1;
      cnt_d      = '0;
    end else if (branchFlush) begin
      ifIdFlush  = 1'b1;
      idIeBubble = 1'b1;
    end else if (multiStart || multiHold) begin
      pcEn    = 1'b0;
      ifIdEn  = 1'b0;
      idIeEn  = 1'b0;
      ieBusy  = 1'b1;
      state_d = MULTI;
      // LAT-2 so that the stall lasts LAT-1 cycles including the start cycle.
      cnt_d   = multiStart ? CNT_W'(op_latency(bus.ie_opcode, MUL_LAT, DIV_LAT) - 2)
                           : cnt_q - 1'b1;
    end else if (loadUse) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idIeBubble = 1'b1;
    end
  end

  // FSM state and latency down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stallInc = !rst && !pcEn;
  assign flushInc = !rst && branchFlush;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallInc),
    .value (bus.stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushInc),
    .value (bus.flush_count)
  );

  assign bus.pc_en        = pcEn;
  assign bus.if_id_en     = ifIdEn;
  assign bus.if_id_flush  = ifIdFlush;
  assign bus.id_ie_en     = idIeEn;
  assign bus.id_ie_bubble = idIeBubble;
  assign bus.ie_busy      = ieBusy;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl (MUL_LAT=4, DIV_LAT=16). Each cycle the
// expected control vector is queued when the inputs are driven and popped
// when the outputs are sampled mid-cycle. A small counter model tracks the
// expected stall/flush counts from the queued control vectors.
// Control vector bit order: {pc_en, if_id_en, if_id_flush, id_ie_en,
//                            id_ie_bubble, ie_busy}
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam logic [5:0] RUN_V     = 6'b110100;
  localparam logic [5:0] RESET_V   = 6'b001010;
  localparam logic [5:0] FLUSH_V   = 6'b111110;
  localparam logic [5:0] MULTI_V   = 6'b000001;
  localparam logic [5:0] LOADUSE_V = 6'b000110;

  logic clk;
  logic rst;

  pipeline_ctrl_if #(.REG_AW(4)) bus ();

  pipeline_ctrl #(.MUL_LAT(4), .DIV_LAT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  expQ[$];
  string       tagQ[$];
  logic [15:0] expStall;
  logic [15:0] expFlush;
  int          testsRun;
  int          testsFailed;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Return all pipeline status inputs to an idle pipeline.
  task automatic clearInputs();
    bus.id_valid        = 1'b0;
    bus.id_src1         = 4'd0;
    bus.id_src1_used    = 1'b0;
    bus.id_src2         = 4'd0;
    bus.id_src2_used    = 1'b0;
    bus.ie_valid        = 1'b0;
    bus.ie_opcode       = OP_NOP;
    bus.ie_dest         = 4'd0;
    bus.ie_is_load      = 1'b0;
    bus.ie_branch_taken = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected controls for the inputs just driven and update the
  // expected debug counters for this cycle.
  task automatic applyStimulus(input string tag, input logic [5:0] exp);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    if (rst) begin
      expStall = 16'd0;
      expFlush = 16'd0;
    end else begin
      if (!exp[5]) expStall = satInc(expStall);
      if (exp == FLUSH_V) expFlush = satInc(expFlush);
    end
  endtask

  // Sample the controls mid-cycle and compare with the oldest queued entry.
  task automatic checkOutput();
    logic [5:0] obs;
    logic [5:0] exp;
    string      tag;
    #1;
    obs = {bus.pc_en, bus.if_id_en, bus.if_id_flush,
           bus.id_ie_en, bus.id_ie_bubble, bus.ie_busy};
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty: observed %b required an entry", obs);
    end else begin
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      assert (obs === exp) else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  // Compare both debug counters against the model.
  task automatic checkCounts(input string tag);
    testsRun++;
    assert (bus.stall_count === expStall) else begin
      testsFailed++;
      $error("[TB] FAIL %s_stall: observed %0d expected %0d", tag, bus.stall_count, expStall);
    end
    testsRun++;
    assert (bus.flush_count === expFlush) else begin
      testsFailed++;
      $error("[TB] FAIL %s_flush: observed %0d expected %0d", tag, bus.flush_count, expFlush);
    end
  endtask

  // One directed step: drive is done by the caller, then queue + check.
  task automatic step(input string tag, input logic [5:0] exp);
    applyStimulus(tag, exp);
    checkOutput();
    nextCycle();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expStall    = 16'd0;
    expFlush    = 16'd0;
    clearInputs();
    rst = 1'b1;
    nextCycle();

    // Reset with a MUL sitting in IE must not start a multi-cycle op.
    bus.ie_valid  = 1'b1;
    bus.ie_opcode = OP_MUL;
    for (int i = 0; i < 3; i++) step("reset_hold", RESET_V);
    rst = 1'b0;
    clearInputs();
    checkCounts("after_reset");
    step("idle_after_reset", RUN_V);

    // Load-use through src2: one bubble, then proceed against the bubble.
    bus.ie_valid     = 1'b1;
    bus.ie_is_load   = 1'b1;
    bus.ie_dest      = 4'd3;
    bus.id_valid     = 1'b1;
    bus.id_src1      = 4'd7;
    bus.id_src1_used = 1'b1;
    bus.id_src2      = 4'd3;
    bus.id_src2_used = 1'b1;
    step("loaduse_src2", LOADUSE_V);
    bus.ie_valid = 1'b0;
    step("loaduse_release", RUN_V);
    checkCounts("loaduse");

    // Load-use through src1 on register 0.
    bus.ie_valid = 1'b1;
    bus.ie_dest  = 4'd0;
    bus.id_src1  = 4'd0;
    step("loaduse_src1_r0", LOADUSE_V);
    // Matching index but source not used: no hazard.
    bus.id_src1_used = 1'b0;
    bus.id_src2      = 4'd5;
    step("unused_src_match", RUN_V);
    // Match with a non-load in IE: no hazard.
    bus.id_src1_used = 1'b1;
    bus.ie_is_load   = 1'b0;
    step("nonload_match", RUN_V);
    // Match with ID invalid: no hazard.
    bus.ie_is_load = 1'b1;
    bus.id_valid   = 1'b0;
    step("id_invalid_match", RUN_V);
    clearInputs();
    checkCounts("after_hazards");

    // MUL: 3 frozen cycles, branch ignored while held, released on the 4th.
    bus.ie_valid  = 1'b1;
    bus.ie_opcode = OP_MUL;
    step("mul_start", MULTI_V);
    bus.ie_branch_taken = 1'b1;
    step("mul_hold_branch_ignored", MULTI_V);
    bus.ie_branch_taken = 1'b0;
    step("mul_hold_last", MULTI_V);
    step("mul_release", RUN_V);
    clearInputs();
    checkCounts("after_mul");

    // Branch together with a load-use hazard: flush only, no stall.
    bus.ie_valid        = 1'b1;
    bus.ie_is_load      = 1'b1;
    bus.ie_dest         = 4'd3;
    bus.id_valid        = 1'b1;
    bus.id_src2         = 4'd3;
    bus.id_src2_used    = 1'b1;
    bus.ie_branch_taken = 1'b1;
    step("branch_over_loaduse", FLUSH_V);
    clearInputs();
    checkCounts("after_branch");

    // Branch on the release cycle of a MUL is honoured.
    bus.ie_valid  = 1'b1;
    bus.ie_opcode = OP_MUL;
    for (int i = 0; i < 3; i++) step("mul2_stall", MULTI_V);
    bus.ie_branch_taken = 1'b1;
    step("mul2_release_branch", FLUSH_V);
    clearInputs();
    checkCounts("after_mul2");

    // DIV interrupted by reset when the down-counter reads 7.
    bus.ie_valid  = 1'b1;
    bus.ie_opcode = OP_DIV;
    for (int i = 0; i < 8; i++) step("div_stall", MULTI_V);
    rst = 1'b1;
    step("div_reset", RESET_V);
    rst = 1'b0;
    clearInputs();
    checkCounts("after_div_reset");
    step("run_after_div_reset", RUN_V);

    // Saturation: a persistent load-use hazard stalls every cycle.
    bus.ie_valid     = 1'b1;
    bus.ie_is_load   = 1'b1;
    bus.ie_dest      = 4'd9;
    bus.id_valid     = 1'b1;
    bus.id_src1      = 4'd9;
    bus.id_src1_used = 1'b1;
    step("sat_first", LOADUSE_V);
    for (int i = 1; i < 70000; i++) begin
      expStall = satInc(expStall);
      nextCycle();
    end
    checkCounts("saturated");
    step("sat_still_stalling", LOADUSE_V);
    checkCounts("saturated_hold");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
